// File: rtl/sha256_round_core.sv
// SHA-256 compression core, one round per clock.
// Define SHA256_CHAIN_EN to chain blocks of a multi-block message.
module sha256_round_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         busy,
  output logic         dig_valid,
  output logic [255:0] dig_data
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              fin_q, fin_d;
  logic [7:0][31:0]  v_q, v_d;
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      cv_q, cv_d;
  logic [255:0]      dig_q, dig_d;
  logic [255:0]      base;
  logic [31:0]       s0, s1, ch, maj, t1, t2, wn;

`ifdef SHA256_CHAIN_EN
  assign base = blk_first ? IV : dig_q;
`else
  logic unused_first;
  assign unused_first = blk_first;
  assign base = IV;
`endif

  // v_q[7..0] = a..h; w_q[15] is W(t), w_q[0] is W(t+15)
  always_comb begin
    s1  = rotr(v_q[3], 6) ^ rotr(v_q[3], 11) ^ rotr(v_q[3], 25);
    ch  = (v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1]);
    t1  = v_q[0] + s1 + ch + K[cnt_q] + w_q[15];
    s0  = rotr(v_q[7], 2) ^ rotr(v_q[7], 13) ^ rotr(v_q[7], 22);
    maj = (v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]);
    t2  = s0 + maj;
    wn  = sig1(w_q[1]) + w_q[6] + sig0(w_q[14]) + w_q[15];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    v_d       = v_q;
    w_d       = w_q;
    cv_d      = cv_q;
    dig_d     = dig_q;
    blk_ready = 1'b0;
    busy      = 1'b1;
    dig_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) begin
          state_d = ROUND;
          cnt_d   = '0;
          fin_d   = 1'b0;
          v_d     = base;
          cv_d    = base;
          w_d     = blk_data;
        end
      end
      ROUND: begin
        if (fin_q) begin
          for (int i = 0; i < 8; i++)
            dig_d[32*i +: 32] = cv_q[32*i +: 32] + v_q[i];
          state_d = DONE;
        end else begin
          v_d = {t1 + t2, v_q[7:5], v_q[4] + t1, v_q[3:1]};
          w_d = {w_q[14:0], wn};
          if (cnt_q == LAST) fin_d = 1'b1;
          else cnt_d = cnt_q + 6'd1;
        end
      end
      DONE: begin
        dig_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      v_q     <= '0;
      w_q     <= '0;
      cv_q    <= IV;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      v_q     <= v_d;
      w_q     <= w_d;
      cv_q    <= cv_d;
      dig_q   <= dig_d;
    end
  end

  assign dig_data = dig_q;
endmodule

// File: tb/tb_sha256_round_core.sv
// Directed-vector bench for sha256_round_core.
// Build with SHA256_CHAIN_EN to exercise two-block chaining.
module tb_sha256_round_core;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         busy;
  logic         dig_valid;
  logic [255:0] dig_data;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] B_TWO2 = {480'h0, 32'h000001c0};

  sha256_round_core #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .busy      (busy),
    .dig_valid (dig_valid),
    .dig_data  (dig_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept edge E0 happens inside; returns at E0+1
  task automatic send(input logic [511:0] d, input logic first);
    int n;
    n = 0;
    while (!blk_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_ready", blk_ready, 1'b1);
    blk_valid = 1'b1;
    blk_data  = d;
    blk_first = first;
    tick();
    blk_valid = 1'b0;
  endtask

  // counts edges from E0 until dig_valid is seen
  task automatic wait_dig(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!dig_valid && lat < 200);
  endtask

  task automatic run_block(input string tag, input logic [511:0] d,
                           input logic first, input logic [255:0] exp);
    int lat;
    send(d, first);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_notready"}, blk_ready, 1'b0);
    wait_dig(lat);
    chk({tag, "_lat"}, 256'(lat), 256'd65);
    chk({tag, "_dig"}, dig_data, exp);
    tick();
    chk({tag, "_pulse"}, dig_valid, 1'b0);
    chk({tag, "_idle"}, blk_ready, 1'b1);
    chk({tag, "_hold"}, dig_data, exp);
  endtask

  initial begin
    int n;
    int bad_ready;
    int pulses;
    logic [511:0] junk;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", blk_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dv", dig_valid, 1'b0);
    chk("rst_dig", dig_data, 256'h0);
    rst = 1'b0;
    tick();

    run_block("abc", B_ABC, 1'b1, D_ABC);
    run_block("empty", B_EMPTY, 1'b1, D_EMPTY);

    // blk_valid held high with changing data throughout ROUND
    blk_valid = 1'b1;
    blk_first = 1'b1;
    blk_data  = B_ABC;
    tick();
    n = 0;
    bad_ready = 0;
    do begin
      for (int k = 0; k < 16; k++) junk[32*k +: 32] = $urandom();
      blk_data = junk;
      tick();
      n++;
      if (blk_ready) bad_ready++;
    end while (!dig_valid && n < 200);
    chk("hold_lat", 256'(n), 256'd65);
    chk("hold_ready_low", 256'(bad_ready), 256'd0);
    chk("hold_dig", dig_data, D_ABC);
    blk_data = B_EMPTY;
    tick();
    chk("hold_e66_idle", busy, 1'b0);
    tick();
    chk("hold_e67_accept", busy, 1'b1);
    blk_valid = 1'b0;
    wait_dig(n);
    chk("hold2_lat", 256'(n), 256'd65);
    chk("hold2_dig", dig_data, D_EMPTY);
    tick();

    // asynchronous reset mid-round
    send(B_ABC, 1'b1);
    repeat (29) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ready", blk_ready, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_dv", dig_valid, 1'b0);
    chk("mrst_dig", dig_data, 256'h0);
    pulses = 0;
    repeat (2) begin
      tick();
      if (dig_valid) pulses++;
    end
    rst = 1'b0;
    repeat (80) begin
      tick();
      if (dig_valid) pulses++;
    end
    chk("mrst_nopulse", 256'(pulses), 256'd0);
    run_block("abc_after_rst", B_ABC, 1'b1, D_ABC);

`ifdef SHA256_CHAIN_EN
    send(B_TWO1, 1'b1);
    wait_dig(n);
    tick();
    run_block("two_blk", B_TWO2, 1'b0, D_TWO);
`else
    run_block("nochain_1", B_ABC, 1'b1, D_ABC);
    run_block("nochain_2", B_ABC, 1'b0, D_ABC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_round_core.md
SHA256_ROUND_CORE -- requirements
Module: sha256_round_core

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: number of compression rounds per block; legal 1..64; only 64 gives standard SHA-256.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port blk_valid  input  1  a 512-bit message block is offered.
REQ-005 SHALL have port blk_ready  output  1  the core can accept a block.
REQ-006 SHALL have port blk_data  input  512  padded block; word W0 = blk_data[511:480], W15 = blk_data[31:0].
REQ-007 SHALL have port blk_first  input  1  block starts a new message; sampled with blk_data.
REQ-008 SHALL have port busy  output  1  a block is being compressed.
REQ-009 SHALL have port dig_valid  output  1  one-cycle pulse: dig_data holds a new digest.
REQ-010 SHALL have port dig_data  output  256  digest H0..H7; H0 = dig_data[255:224].

Function
REQ-011 SHALL implement states IDLE, ROUND and DONE.
REQ-012 In IDLE, SHALL drive blk_ready=1 and busy=0; in ROUND and DONE, blk_ready=0 and busy=1.
REQ-013 SHALL accept a block only on an edge with blk_valid=1 and blk_ready=1 (edge E0); blk_valid at other times SHALL be ignored.
REQ-014 At E0, SHALL load the 16-word schedule window from blk_data, load a..h from the chaining value (REQ-024/025), clear the round counter and enter ROUND.
REQ-015 SHALL perform exactly one round per cycle at edges E1..E_ROUNDS, using the standard Ch, Maj, Σ0 and Σ1 functions and constant K[t].
REQ-016 SHALL supply Wt from the window for t<16; for t>=16, Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, with all additions mod 2^32.
REQ-017 SHALL shift the window by one word per round.
REQ-018 At edge E_ROUNDS+1, SHALL add a..h to the chaining value word-wise mod 2^32, register the result on dig_data and enter DONE.
REQ-019 In DONE, SHALL drive dig_valid=1 for exactly that cycle, then return to IDLE on the next edge.
REQ-020 With ROUNDS=64, SHALL assert dig_valid in the cycle after edge E65, and SHALL allow the earliest next accept at E67.
REQ-021 SHALL hold dig_data stable from DONE until the next DONE.
REQ-022 The round counter SHALL be 6 bits and SHALL leave ROUND when the count reaches ROUNDS-1; it SHALL never wrap.

Reset
REQ-023 Asserting rst in any state SHALL immediately force IDLE, blk_ready=1, busy=0, dig_valid=0, dig_data=0, round counter=0, the chaining value to the SHA-256 IV, and SHALL discard any in-flight block with no digest pulse.

Configuration
REQ-024 With macro SHA256_CHAIN_EN defined: SHALL use the SHA-256 IV as chaining value when blk_first=1, and the previous digest (dig_data) otherwise; multi-block messages SHALL then hash correctly.
REQ-025 Without SHA256_CHAIN_EN: SHALL ignore blk_first and use the IV for every block, so each block yields an independent single-block digest.

Verification
REQ-026 Reset, then "abc" padded block (blk_data starts 61626380, last word 00000018), blk_first=1 -> one dig_valid pulse after E65 with dig_data = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-027 Empty-message block (80000000, then all zero), blk_first=1 -> dig_data = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-028 SHA256_CHAIN_EN defined: the two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first with blk_first=1 and second with blk_first=0 -> second digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-029 Hold blk_valid=1 with changing blk_data throughout ROUND -> blk_ready=0, the digest equals the first accepted block's digest, and the next accept occurs at E67.
REQ-030 Assert rst at E30 mid-ROUND -> outputs immediately take reset values with no dig_valid; a subsequent "abc" block still gives the REQ-026 digest.
REQ-031 Without SHA256_CHAIN_EN: "abc" sent twice, the second with blk_first=0 -> both digests equal the REQ-026 value.
